// File: rtl/dpram_port_b_requester.sv
// Port B master for the dual-port RAM: takes one client request at a time, issues it,
// retries while Port A holds the address (busy_B), and returns data or an error.
module dpram_port_b_requester #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 8,
   parameter int MAX_RETRY = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [7:0]        rsp_retries,
   output logic              ram_we_B,
   output logic [ADDR_W-1:0] ram_addr_B,
   output logic [DATA_W-1:0] ram_din_B,
   input  logic [DATA_W-1:0] ram_dout_B,
   input  logic              ram_busy_B
);

   typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RESP} state_t;

   localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                we_l_q, we_l_d;
   logic [ADDR_W-1:0]   addr_l_q, addr_l_d;
   logic [DATA_W-1:0]   wdata_l_q, wdata_l_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_din_q, ram_din_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_l_d      = we_l_q;
      addr_l_d    = addr_l_q;
      wdata_l_d   = wdata_l_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_din_d   = ram_din_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               we_l_d     = req_we;
               addr_l_d   = req_addr;
               wdata_l_d  = req_wdata;
               cnt_d      = '0;
               ram_we_d   = req_we;
               ram_addr_d = req_addr;
               ram_din_d  = req_wdata;
               state_d    = ISSUE;
            end
         end
         // Address stays on the bus in CHECK so the RAM does a harmless read.
         ISSUE: state_d = CHECK;
         CHECK: begin
            if (!ram_busy_B) begin
               rsp_rdata_d = we_l_q ? '0 : ram_dout_B;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (cnt_q < MAX_R) begin
               cnt_d    = cnt_q + 8'd1;
               ram_we_d = we_l_q;
               state_d  = ISSUE;
            end else begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_l_q      <= 1'b0;
         addr_l_q    <= '0;
         wdata_l_q   <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_l_q      <= we_l_d;
         addr_l_q    <= addr_l_d;
         wdata_l_q   <= wdata_l_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_retries = cnt_q;
   assign ram_we_B    = ram_we_q;
   assign ram_addr_B  = ram_addr_q;
   assign ram_din_B   = ram_din_q;

endmodule

// File: tb/tb_dpram_port_b_requester.sv
// Bench for dpram_port_b_requester: a simple dual-port RAM with a scripted Port A
// writer, and a transaction-level model predicting retries, data and latency.
module tb_dpram_port_b_requester;
   localparam int AW = 10;
   localparam int DW = 8;
   localparam int MR = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [7:0]    rsp_retries;
   logic          ram_we_B, ram_busy_B;
   logic [AW-1:0] ram_addr_B;
   logic [DW-1:0] ram_din_B, ram_dout_B;

   // Port A driver and RAM storage
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_din;
   logic [DW-1:0] ram    [0:1023] = '{default: 8'h00};
   logic [DW-1:0] shadow [0:1023] = '{default: 8'h00};
   int            we_total = 0;
   int            n_chk = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;

   dpram_port_b_requester #(.ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_retries(rsp_retries),
      .ram_we_B(ram_we_B), .ram_addr_B(ram_addr_B), .ram_din_B(ram_din_B),
      .ram_dout_B(ram_dout_B), .ram_busy_B(ram_busy_B)
   );

   // Port A wins any edge where it writes the address Port B presents.
   always @(posedge clk) begin
      ram_busy_B <= a_we && (a_addr == ram_addr_B);
      if (a_we) ram[a_addr] <= a_din;
      if (!(a_we && (a_addr == ram_addr_B))) begin
         if (ram_we_B) ram[ram_addr_B] <= ram_din_B;
         ram_dout_B <= ram[ram_addr_B];
      end
      if (ram_we_B) we_total <= we_total + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   // One request from the client's point of view. Port A writes addr aa at edges
   // E+a_st .. E+a_st+a_ln-1 relative to the acceptance edge E.
   task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int a_st, input int a_ln, input logic [AW-1:0] aa,
                          input int hold, input int rst_at);
      int k, s, m, w, hcnt, wc0;
      logic err_e;
      logic [DW-1:0] exp_rd, c_rd;
      logic c_err;
      logic [7:0] c_ret;
      bit seen, done;
      // attempt k reaches the RAM at edge E+1+2k
      k = 0;
      while (k < MR && aa == addr && (1 + 2*k) >= a_st && (1 + 2*k) < a_st + a_ln) k++;
      err_e  = (aa == addr) && (1 + 2*k) >= a_st && (1 + 2*k) < a_st + a_ln;
      s      = 1 + 2*k;
      m      = s + 1;
      exp_rd = '0;
      seen = 0; done = 0; hcnt = 0; c_rd = '0; c_err = 0; c_ret = '0;

      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      w = 0;
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      n_chk++;
      if (!req_ready) begin
         $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
         req_valid = 1'b0;
         return;
      end else n_pass++;
      wc0 = we_total;
      @(posedge clk);
      #1 req_valid = 1'b0;

      for (int j = 1; j < 200; j++) begin
         @(negedge clk);
         if (rst_at == j) begin
            a_we = 1'b0;
            rst  = 1'b1;
            #1;
            n_chk++;
            if ({req_ready, rsp_valid, rsp_err, rsp_rdata, rsp_retries, ram_we_B, ram_addr_B, ram_din_B} !== '0)
               $display("FAIL async_reset_outputs: rdy=%0b vld=%0b err=%0b rd=%0h ret=%0d we=%0b addr=%0h din=%0h required all 0",
                        req_ready, rsp_valid, rsp_err, rsp_rdata, rsp_retries, ram_we_B, ram_addr_B, ram_din_B);
            else n_pass++;
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (!seen) begin
            if (rsp_valid) begin
               seen = 1;
               n_chk++;
               if (j - 1 != m) $display("FAIL rsp_latency: valid after edge E+%0d required E+%0d", j - 1, m);
               else n_pass++;
               n_chk++;
               if (rsp_err !== err_e) $display("FAIL rsp_err: got %0b required %0b", rsp_err, err_e);
               else n_pass++;
               n_chk++;
               if (rsp_retries !== 8'(k)) $display("FAIL rsp_retries: got %0d required %0d", rsp_retries, k);
               else n_pass++;
               n_chk++;
               if (rsp_rdata !== exp_rd) $display("FAIL rsp_rdata: addr %0h got %0h required %0h", addr, rsp_rdata, exp_rd);
               else n_pass++;
               c_rd = rsp_rdata; c_err = rsp_err; c_ret = rsp_retries;
               rsp_ready = (hold == 0);
            end else begin
               n_chk++;
               if (req_ready !== 1'b0) $display("FAIL req_ready_busy: got %0b required 0", req_ready);
               else n_pass++;
               if (j - 1 > m) begin
                  $display("FAIL rsp_timeout: no rsp_valid by edge E+%0d, required at E+%0d", j - 1, m);
                  break;
               end
            end
         end else if (!done) begin
            if (rsp_ready) begin
               done = 1;
               rsp_ready = 1'b0;
               n_chk++;
               if ({rsp_valid, req_ready} !== 2'b01)
                  $display("FAIL handshake_release: valid=%0b ready=%0b required valid=0 ready=1", rsp_valid, req_ready);
               else n_pass++;
               n_chk++;
               if (we_total - wc0 != (we ? k + 1 : 0))
                  $display("FAIL we_pulses: got %0d required %0d", we_total - wc0, we ? k + 1 : 0);
               else n_pass++;
            end else begin
               n_chk++;
               if ({rsp_valid, rsp_rdata, rsp_err, rsp_retries, req_ready} !== {1'b1, c_rd, c_err, c_ret, 1'b0})
                  $display("FAIL rsp_hold_stable: vld=%0b rd=%0h err=%0b ret=%0d rdy=%0b required 1 %0h %0b %0d 0",
                           rsp_valid, rsp_rdata, rsp_err, rsp_retries, req_ready, c_rd, c_err, c_ret);
               else n_pass++;
               hcnt++;
               if (hcnt >= hold) rsp_ready = 1'b1;
            end
         end
         if (done && j >= a_st + a_ln) break;
         // Model the RAM contents at edge E+j, B's successful access first.
         if (j == s && !err_e) begin
            exp_rd = we ? '0 : shadow[addr];
            if (we) shadow[addr] = wd;
         end
         a_we   = (j >= a_st) && (j < a_st + a_ln);
         a_addr = aa;
         a_din  = DW'($urandom);
         if (a_we) shadow[aa] = a_din;
      end
      a_we = 1'b0;
      rsp_ready = 1'b0;
      n_chk++;
      if (!done) $display("FAIL txn_complete: done=%0b required 1", done);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata, rsp_retries, ram_we_B, ram_addr_B, ram_din_B} !== '0)
         $display("FAIL reset_outputs: rdy=%0b vld=%0b ret=%0d required all 0", req_ready, rsp_valid, rsp_retries);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %0b required 1", req_ready);
      else n_pass++;
   endtask

   task automatic test_write_read();
      run_txn(1'b1, 10'h055, 8'hA7, 0, 0, 10'h000, 0, -1);
      run_txn(1'b0, 10'h055, 8'h00, 0, 0, 10'h000, 0, -1);
      n_chk++;
      if (shadow[10'h055] !== 8'hA7) $display("FAIL model_write_read: got %0h required a7", shadow[10'h055]);
      else n_pass++;
   endtask

   task automatic test_porta_collision();
      run_txn(1'b0, 10'h100, 8'h00, 1, 3, 10'h100, 0, -1);
      run_txn(1'b0, 10'h100, 8'h00, 1, 5, 10'h100, 0, -1);
      run_txn(1'b0, 10'h100, 8'h00, 2, 3, 10'h100, 0, -1);
      run_txn(1'b1, 10'h101, 8'h3C, 1, 4, 10'h100, 0, -1);
   endtask

   task automatic test_retry_limit();
      run_txn(1'b1, 10'h1A0, 8'h5A, 1, 40, 10'h1A0, 0, -1);
      run_txn(1'b0, 10'h1A0, 8'h00, 0, 0, 10'h000, 0, -1);
   endtask

   task automatic test_resp_hold();
      run_txn(1'b0, 10'h055, 8'h00, 0, 0, 10'h000, 5, -1);
   endtask

   task automatic test_boundary();
      run_txn(1'b1, 10'h3FF, 8'hFF, 0, 0, 10'h000, 0, -1);
      run_txn(1'b1, 10'h000, 8'h01, 0, 0, 10'h000, 0, -1);
      run_txn(1'b0, 10'h3FF, 8'h00, 0, 0, 10'h000, 0, -1);
      run_txn(1'b0, 10'h000, 8'h00, 0, 0, 10'h000, 0, -1);
   endtask

   task automatic test_reset_mid_retry();
      run_txn(1'b1, 10'h2A0, 8'h77, 1, 40, 10'h2A0, 0, 4);
      run_txn(1'b0, 10'h2A0, 8'h00, 0, 0, 10'h000, 0, -1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++)
         run_txn(1'($urandom), 10'h200 + 10'($urandom_range(0, 3)), DW'($urandom),
                 int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
                 10'h200 + 10'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0;
      a_we = 1'b0; a_addr = '0; a_din = '0;
      test_reset();
      test_write_read();
      test_porta_collision();
      test_retry_limit();
      test_resp_hold();
      test_boundary();
      test_reset_mid_retry();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
